// File: rtl/regfile_wb_sched.sv
// Writeback scheduler: merges ALU and memory-load results into the single
// register-file write port through per-source 2-entry FIFOs, and tracks pending destinations.

module wb_fifo2 #(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          ready,
  output logic          not_empty,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data
);

  logic [AW-1:0] addr_q [2];
  logic [AW-1:0] addr_d [2];
  logic [DW-1:0] data_q [2];
  logic [DW-1:0] data_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    cnt_q, cnt_d;

  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      addr_d[wr_ptr_q] = push_addr;
      data_d[wr_ptr_q] = push_data;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q   <= '{default: '0};
      data_q   <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      addr_q   <= addr_d;
      data_q   <= data_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Ready depends only on registered occupancy, never on the incoming valid.
  assign ready     = (cnt_q != 2'd2);
  assign not_empty = (cnt_q != 2'd0);
  assign head_addr = addr_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];

endmodule

module regfile_wb_sched #(
  parameter int WIDTH         = 32,
  parameter int LOG2_NUM_REGS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        a_valid,
  output logic                        a_ready,
  input  logic [LOG2_NUM_REGS-1:0]    a_addr,
  input  logic [WIDTH-1:0]            a_data,
  input  logic                        m_valid,
  output logic                        m_ready,
  input  logic [LOG2_NUM_REGS-1:0]    m_addr,
  input  logic [WIDTH-1:0]            m_data,
  input  logic                        rsv_valid,
  input  logic [LOG2_NUM_REGS-1:0]    rsv_addr,
  input  logic [LOG2_NUM_REGS-1:0]    q_addr1,
  input  logic [LOG2_NUM_REGS-1:0]    q_addr2,
  output logic                        q_busy1,
  output logic                        q_busy2,
  output logic                        we3,
  output logic [LOG2_NUM_REGS-1:0]    wa3,
  output logic [WIDTH-1:0]            wd3,
  output logic [2**LOG2_NUM_REGS-1:0] pending,
  output logic                        err_pc_write
);

  localparam int NUM_REGS = 2 ** LOG2_NUM_REGS;
  localparam logic [LOG2_NUM_REGS-1:0] PC_ADDR = '1;
  localparam logic [NUM_REGS-1:0] ONE_HOT0 = NUM_REGS'(1);

  typedef enum logic {GNT_A = 1'b0, GNT_M = 1'b1} grant_e;

  grant_e                     last_grant_q, last_grant_d;
  logic                       we3_q, we3_d;
  logic [LOG2_NUM_REGS-1:0]   wa3_q, wa3_d;
  logic [WIDTH-1:0]           wd3_q, wd3_d;
  logic [NUM_REGS-1:0]        pending_q, pending_d;
  logic                       err_q, err_d;

  logic                       a_acc, m_acc, a_push, m_push, a_pop, m_pop;
  logic                       a_ne, m_ne;
  logic [LOG2_NUM_REGS-1:0]   a_head_addr, m_head_addr;
  logic [WIDTH-1:0]           a_head_data, m_head_data;
  logic [NUM_REGS-1:0]        set_mask, clr_mask;

  assign a_acc  = a_valid && a_ready;
  assign m_acc  = m_valid && m_ready;
  // PC-targeted writebacks are consumed but dropped; they only raise the error flag.
  assign a_push = a_acc && (a_addr != PC_ADDR);
  assign m_push = m_acc && (m_addr != PC_ADDR);

  wb_fifo2 #(.AW(LOG2_NUM_REGS), .DW(WIDTH)) u_fifo_a (
    .clk       (clk),
    .rst       (rst),
    .push      (a_push),
    .push_addr (a_addr),
    .push_data (a_data),
    .pop       (a_pop),
    .ready     (a_ready),
    .not_empty (a_ne),
    .head_addr (a_head_addr),
    .head_data (a_head_data)
  );

  wb_fifo2 #(.AW(LOG2_NUM_REGS), .DW(WIDTH)) u_fifo_m (
    .clk       (clk),
    .rst       (rst),
    .push      (m_push),
    .push_addr (m_addr),
    .push_data (m_data),
    .pop       (m_pop),
    .ready     (m_ready),
    .not_empty (m_ne),
    .head_addr (m_head_addr),
    .head_data (m_head_data)
  );

  always_comb begin
    a_pop        = a_ne && (!m_ne || (last_grant_q == GNT_M));
    m_pop        = m_ne && !a_pop;
    last_grant_d = last_grant_q;
    we3_d        = a_pop || m_pop;
    wa3_d        = wa3_q;
    wd3_d        = wd3_q;
    if (a_pop) begin
      last_grant_d = GNT_A;
      wa3_d        = a_head_addr;
      wd3_d        = a_head_data;
    end else if (m_pop) begin
      last_grant_d = GNT_M;
      wa3_d        = m_head_addr;
      wd3_d        = m_head_data;
    end
    clr_mask  = we3_d ? (ONE_HOT0 << wa3_d) : '0;
    set_mask  = (rsv_valid && (rsv_addr != PC_ADDR)) ? (ONE_HOT0 << rsv_addr) : '0;
    // A new reservation outranks the retiring write to the same register.
    pending_d = (pending_q & ~clr_mask) | set_mask;
    err_d     = err_q || (a_acc && (a_addr == PC_ADDR)) || (m_acc && (m_addr == PC_ADDR));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= GNT_M;
      we3_q        <= 1'b0;
      wa3_q        <= '0;
      wd3_q        <= '0;
      pending_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      we3_q        <= we3_d;
      wa3_q        <= wa3_d;
      wd3_q        <= wd3_d;
      pending_q    <= pending_d;
      err_q        <= err_d;
    end
  end

  assign we3          = we3_q;
  assign wa3          = wa3_q;
  assign wd3          = wd3_q;
  assign pending      = pending_q;
  assign err_pc_write = err_q;
  assign q_busy1      = (q_addr1 != PC_ADDR) && pending_q[q_addr1];
  assign q_busy2      = (q_addr2 != PC_ADDR) && pending_q[q_addr2];

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: expected writes go into a queue, a
// negedge monitor pops and compares every we3 pulse against it.

module tb_regfile_wb_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_ready, m_valid, m_ready;
  logic [3:0]  a_addr, m_addr, rsv_addr, q_addr1, q_addr2, wa3;
  logic [31:0] a_data, m_data, wd3;
  logic        rsv_valid, q_busy1, q_busy2, we3, err_pc_write;
  logic [15:0] pending;

  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_chk  = 0;
  int  n_pass = 0;

  regfile_wb_sched #(.WIDTH(32), .LOG2_NUM_REGS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .a_valid      (a_valid),
    .a_ready      (a_ready),
    .a_addr       (a_addr),
    .a_data       (a_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_addr       (m_addr),
    .m_data       (m_data),
    .rsv_valid    (rsv_valid),
    .rsv_addr     (rsv_addr),
    .q_addr1      (q_addr1),
    .q_addr2      (q_addr2),
    .q_busy1      (q_busy1),
    .q_busy2      (q_busy2),
    .we3          (we3),
    .wa3          (wa3),
    .wd3          (wd3),
    .pending      (pending),
    .err_pc_write (err_pc_write)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [3:0] addr, input logic [31:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: every write pulse must match the next expected entry.
  always @(negedge clk) begin
    if (rst && we3) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_write: got wa3=%0h wd3=%0h expected no write", wa3, wd3);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(wa3), 64'(e.addr));
        check("wr_data", 64'(wd3), 64'(e.data));
      end
    end
  end

  initial begin
    rst = 1'b0; a_valid = 0; m_valid = 0; rsv_valid = 0;
    a_addr = 0; m_addr = 0; a_data = 0; m_data = 0;
    rsv_addr = 0; q_addr1 = 0; q_addr2 = 0;
    #2;
    check("rst_a_ready", 64'(a_ready), 64'd1);
    check("rst_m_ready", 64'(m_ready), 64'd1);
    check("rst_we3", 64'(we3), 64'd0);
    check("rst_wa3", 64'(wa3), 64'd0);
    check("rst_wd3", 64'(wd3), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_err", 64'(err_pc_write), 64'd0);
    #10 rst = 1'b1;
    #1;
    check("post_rst_a_ready", 64'(a_ready), 64'd1);
    check("post_rst_m_ready", 64'(m_ready), 64'd1);
    tick();
    check("idle_we3", 64'(we3), 64'd0);

    // Contention right after reset: A wins the first tie.
    expect_wr(4'd1, 32'h0000_00A0);
    expect_wr(4'd2, 32'h0000_00B0);
    expect_wr(4'd3, 32'h0000_00A1);
    expect_wr(4'd4, 32'h0000_00B1);
    a_valid = 1; a_addr = 4'd1; a_data = 32'hA0;
    m_valid = 1; m_addr = 4'd2; m_data = 32'hB0;
    tick();
    a_addr = 4'd3; a_data = 32'hA1;
    m_addr = 4'd4; m_data = 32'hB1;
    check("cont_a_ready_e1", 64'(a_ready), 64'd1);
    check("cont_m_ready_e1", 64'(m_ready), 64'd1);
    tick();
    a_valid = 0; m_valid = 0;
    check("cont_m_full", 64'(m_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      check("cont_we3_run", 64'(we3), 64'd1);
      tick();
    end
    check("cont_we3_done", 64'(we3), 64'd0);
    tick();

    // Single ALU write with reservation and latency.
    rsv_valid = 1; rsv_addr = 4'd3; q_addr1 = 4'd3;
    tick();
    rsv_valid = 0;
    check("rsv3_busy1", 64'(q_busy1), 64'd1);
    check("rsv3_pending", 64'(pending), 64'h0008);
    expect_wr(4'd3, 32'hDEAD_BEEF);
    a_valid = 1; a_addr = 4'd3; a_data = 32'hDEAD_BEEF;
    tick();
    a_valid = 0;
    check("lat_we3_k", 64'(we3), 64'd0);
    check("lat_busy_k", 64'(q_busy1), 64'd1);
    tick();
    check("lat_we3_k1", 64'(we3), 64'd1);
    check("lat_pending_clr", 64'(pending[3]), 64'd0);
    check("lat_busy_clr", 64'(q_busy1), 64'd0);
    tick();
    check("lat_we3_pulse", 64'(we3), 64'd0);

    // PC write and PC reservation.
    m_valid = 1; m_addr = 4'd15; m_data = 32'h1234;
    rsv_valid = 1; rsv_addr = 4'd15; q_addr2 = 4'd15;
    check("pc_m_ready", 64'(m_ready), 64'd1);
    tick();
    m_valid = 0; rsv_valid = 0;
    check("pc_err_set", 64'(err_pc_write), 64'd1);
    check("pc_pending", 64'(pending), 64'd0);
    check("pc_busy2", 64'(q_busy2), 64'd0);
    for (int i = 0; i < 3; i++) tick();
    check("pc_err_sticky", 64'(err_pc_write), 64'd1);

    // Backpressure: 5 back-to-back ALU pushes drain at one per cycle.
    a_valid = 1;
    for (int i = 0; i < 5; i++) begin
      a_addr = 4'(6 + i);
      a_data = 32'h100 + 32'(i);
      check("bp_a_ready", 64'(a_ready), 64'd1);
      expect_wr(4'(6 + i), 32'h100 + 32'(i));
      tick();
    end
    a_valid = 0;
    check("bp_a_ready_end", 64'(a_ready), 64'd1);
    for (int i = 0; i < 3; i++) tick();

    // Set/clear collision on r5.
    expect_wr(4'd5, 32'h55);
    a_valid = 1; a_addr = 4'd5; a_data = 32'h55;
    tick();
    a_valid = 0; rsv_valid = 1; rsv_addr = 4'd5;
    tick();
    rsv_valid = 0;
    check("coll_we3", 64'(we3), 64'd1);
    check("coll_pending5", 64'(pending[5]), 64'd1);
    expect_wr(4'd5, 32'h56);
    a_valid = 1; a_data = 32'h56;
    tick();
    a_valid = 0;
    tick();
    check("coll_pending5_clr", 64'(pending[5]), 64'd0);
    tick();

    // Reset mid-operation. Last grant is A here, so M0 wins the first tie.
    expect_wr(4'd2, 32'hB0B0);
    a_valid = 1; a_addr = 4'd1; a_data = 32'hA0A0;
    m_valid = 1; m_addr = 4'd2; m_data = 32'hB0B0;
    rsv_valid = 1; rsv_addr = 4'd12; q_addr2 = 4'd12;
    tick();
    rsv_valid = 0;
    check("mid_busy2", 64'(q_busy2), 64'd1);
    a_data = 32'hA1A1; m_data = 32'hB1B1;
    tick();
    check("mid_a_full", 64'(a_ready), 64'd0);
    a_data = 32'hA2A2; m_data = 32'hB2B2;
    tick();
    check("mid_we3_before_rst", 64'(we3), 64'd1);
    #1 rst = 1'b0;
    #1;
    a_valid = 0; m_valid = 0;
    check("mid_rst_we3", 64'(we3), 64'd0);
    check("mid_rst_wa3", 64'(wa3), 64'd0);
    check("mid_rst_wd3", 64'(wd3), 64'd0);
    check("mid_rst_pending", 64'(pending), 64'd0);
    check("mid_rst_err", 64'(err_pc_write), 64'd0);
    check("mid_rst_a_ready", 64'(a_ready), 64'd1);
    check("mid_rst_m_ready", 64'(m_ready), 64'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("after_rst_we3", 64'(we3), 64'd0);
    end
    check("after_rst_pending", 64'(pending), 64'd0);
    check("after_rst_busy2", 64'(q_busy2), 64'd0);
    check("drain_queue", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish before 50000");
    $fatal(1, "timeout");
  end

endmodule
